pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/pipeline_ctrl_if.sv | 43 ++++
 rtl/pipeline_ctrl_hazard_detect.sv | 20 ++
 rtl/pipeline_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the pipeline controller.
// Control vectors are ordered {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
// exmem_en, exmem_flush, memwb_en, memwb_flush}.
package cpu_types_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        HALT     = 2'd2
    } pipe_state_t;

    localparam logic [15:0] FLUSH_CNT_MAX = 16'hFFFF;

    localparam logic [8:0] CTRL_ALL_OFF    = 9'b000_000_000;
    localparam logic [8:0] CTRL_NORMAL     = 9'b110_101_010;
    localparam logic [8:0] CTRL_DATA_WAIT  = 9'b000_000_011;
    localparam logic [8:0] CTRL_REDIRECT   = 9'b111_111_010;
    localparam logic [8:0] CTRL_BUBBLE     = 9'b000_111_010;
    localparam logic [8:0] CTRL_FETCH_HOLD = 9'b000_101_010;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Port bundle for the pipeline controller; the controller modport is the
// design's view, the driver modport is the surrounding datapath's view.
interface pipeline_ctrl_if;
    import cpu_types_pkg::*;

    logic                 ihit;
    logic                 dhit;
    logic                 exmem_dREN;
    logic                 exmem_dWEN;
    logic                 idex_memread;
    logic [REG_IDX_W-1:0] idex_rt;
    logic [REG_IDX_W-1:0] ifid_rs;
    logic [REG_IDX_W-1:0] ifid_rt;
    logic                 ex_redirect;
    logic                 wb_halt;
    logic                 pc_en;
    logic                 ifid_en;
    logic                 ifid_flush;
    logic                 idex_en;
    logic                 idex_flush;
    logic                 exmem_en;
    logic                 exmem_flush;
    logic                 memwb_en;
    logic                 memwb_flush;
    logic                 halted;
    logic [31:0]          stall_cnt;
    logic [15:0]          flush_cnt;

    modport controller (
        input  ihit, dhit, exmem_dREN, exmem_dWEN, idex_memread, idex_rt,
               ifid_rs, ifid_rt, ex_redirect, wb_halt,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               exmem_flush, memwb_en, memwb_flush, halted, stall_cnt, flush_cnt
    );

    modport driver (
        output ihit, dhit, exmem_dREN, exmem_dWEN, idex_memread, idex_rt,
               ifid_rs, ifid_rt, ex_redirect, wb_halt,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               exmem_flush, memwb_en, memwb_flush, halted, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds an
// instruction in decode. Register 0 never creates a dependency.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic                 i_idex_memread,
    input  logic [REG_IDX_W-1:0] i_idex_rt,
    input  logic [REG_IDX_W-1:0] i_ifid_rs,
    input  logic [REG_IDX_W-1:0] i_ifid_rt,
    output logic                 o_load_use
);

    logic w_rt_nonzero;
    logic w_src_match;

    assign w_rt_nonzero = (i_idex_rt != {REG_IDX_W{1'b0}});
    assign w_src_match  = (i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt);
    assign o_load_use   = i_idex_memread && w_rt_nonzero && w_src_match;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: resolves halt, data wait, redirect,
// load-use and fetch wait each cycle and keeps stall/flush statistics.
module pipeline_ctrl
    import cpu_types_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ihit,
    input  logic                 dhit,
    input  logic                 exmem_dREN,
    input  logic                 exmem_dWEN,
    input  logic                 idex_memread,
    input  logic [REG_IDX_W-1:0] idex_rt,
    input  logic [REG_IDX_W-1:0] ifid_rs,
    input  logic [REG_IDX_W-1:0] ifid_rt,
    input  logic                 ex_redirect,
    input  logic                 wb_halt,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 ifid_flush,
    output logic                 idex_en,
    output logic                 idex_flush,
    output logic                 exmem_en,
    output logic                 exmem_flush,
    output logic                 memwb_en,
    output logic                 memwb_flush,
    output logic                 halted,
    output logic [31:0]          stall_cnt,
    output logic [15:0]          flush_cnt
);

    pipe_state_t r_state;
    pipe_state_t w_next_state;
    logic [31:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        r_halted;
    logic [8:0]  w_ctrl;
    logic        w_load_use;
    logic        w_data_wait;
    logic        w_state_legal;
    logic        w_flush_inc;
    logic        w_stall_inc;

    hazard_detect u_hazard_detect (
        .i_idex_memread (idex_memread),
        .i_idex_rt      (idex_rt),
        .i_ifid_rs      (ifid_rs),
        .i_ifid_rt      (ifid_rt),
        .o_load_use     (w_load_use)
    );

    assign w_data_wait = (exmem_dREN || exmem_dWEN) && !dhit;

    // Unused state encodings fall back to RUN instead of locking up.
    always_comb begin
        case (r_state)
            RUN:      w_state_legal = 1'b1;
            REDIRECT: w_state_legal = 1'b1;
            HALT:     w_state_legal = 1'b1;
            default:  w_state_legal = 1'b0;
        endcase
    end

    // Priority resolution; in REDIRECT the IF/ID latch already holds a bubble,
    // so a redirect or load-use seen there is stale and ignored.
    always_comb begin
        w_ctrl       = CTRL_NORMAL;
        w_flush_inc  = 1'b0;
        w_next_state = r_state;
        if (RST) begin
            w_ctrl       = CTRL_ALL_OFF;
            w_next_state = RUN;
        end else if (!w_state_legal) begin
            w_ctrl       = CTRL_ALL_OFF;
            w_next_state = RUN;
        end else if ((r_state == HALT) || wb_halt) begin
            w_ctrl       = CTRL_ALL_OFF;
            w_next_state = HALT;
        end else if (w_data_wait) begin
            w_ctrl       = CTRL_DATA_WAIT;
            w_next_state = r_state;
        end else if (r_state == REDIRECT) begin
            if (ihit) begin
                w_ctrl       = CTRL_REDIRECT;
                w_flush_inc  = 1'b1;
                w_next_state = RUN;
            end else begin
                w_ctrl       = CTRL_FETCH_HOLD;
                w_next_state = REDIRECT;
            end
        end else if (ex_redirect) begin
            w_ctrl      = CTRL_REDIRECT;
            w_flush_inc = 1'b1;
            if (ihit) begin
                w_next_state = RUN;
            end else begin
                w_next_state = REDIRECT;
            end
        end else if (w_load_use || !ihit) begin
            w_ctrl       = CTRL_BUBBLE;
            w_next_state = RUN;
        end else begin
            w_ctrl       = CTRL_NORMAL;
            w_next_state = RUN;
        end
    end

    assign {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
            exmem_en, exmem_flush, memwb_en, memwb_flush} = w_ctrl;

    assign w_stall_inc = !w_ctrl[8] && (r_state != HALT) && !wb_halt;

    // State, halt flag and statistics counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= RUN;
            r_halted    <= 1'b0;
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            r_state  <= w_next_state;
            r_halted <= (w_next_state == HALT);
            if (w_stall_inc) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush_inc && (r_flush_cnt != FLUSH_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign halted    = r_halted;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
